fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive identical samples required before a new word is armed (legal range 1..255).
REQ-002 SHALL have parameter COEF_W, default 16, meaning the width of each coefficient; 2*COEF_W SHALL equal 32.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port user_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port reg_data, input, 32 bits: the coefficient word from the software register, already in the user_clk domain; [31:16] is b10 and [15:0] is b11.
REQ-006 SHALL have port sync_in, input, 1 bit: the frame sync pulse; coefficients change only on this event.
REQ-007 SHALL have port en, input, 1 bit: when low, no new update is started.
REQ-008 SHALL have port b10, output, COEF_W bits: the active signed coefficient b10.
REQ-009 SHALL have port b11, output, COEF_W bits: the active signed coefficient b11.
REQ-010 SHALL have port coeff_valid, output, 1 bit: high once at least one update has been applied.
REQ-011 SHALL have port update_pulse, output, 1 bit: a one-cycle strobe on each applied update.
REQ-012 SHALL have port pending, output, 1 bit: high while the state is SETTLE or ARMED.
REQ-013 SHALL have port update_count, output, 8 bits: the number of applied updates, wrapping from 255 to 0.

Function
REQ-014 SHALL register reg_data into reg_q every cycle; the FSM SHALL use only reg_q.
REQ-015 SHALL implement the FSM states IDLE, SETTLE and ARMED.
REQ-016 In IDLE with en=1 and reg_q != active, SHALL load candidate<=reg_q, clear the counter and go to SETTLE.
REQ-017 In SETTLE, reg_q != candidate SHALL reload candidate and clear the counter; otherwise the counter increments, and when the counter reaches SETTLE_CYCLES-1 the FSM SHALL go to ARMED.
REQ-018 In ARMED, reg_q != candidate SHALL return the FSM to SETTLE with the new candidate and a cleared counter; this takes priority over a simultaneous sync_in, and no update occurs.
REQ-019 In ARMED with sync_in=1 and reg_q == candidate, SHALL set active<=candidate, assert update_pulse the next cycle for exactly one cycle, increment update_count, set coeff_valid, and go to IDLE.
REQ-020 sync_in in IDLE or SETTLE SHALL be ignored.
REQ-021 en deasserting in SETTLE or ARMED SHALL NOT abort the pending update; en gates only the IDLE exit.
REQ-022 reg_q equal to active in SETTLE SHALL still complete normally; the re-application is harmless and is counted.
REQ-023 Latency: a reg_data change at edge t SHALL give SETTLE at t+2 and ARMED at t+1+SETTLE_CYCLES; an ARMED sync at edge s SHALL update b10/b11 at s+1.
REQ-024 b10 SHALL equal active[31:16] and b11 SHALL equal active[15:0], registered, with no arithmetic.
REQ-025 A reg_data value equal to active at reset (0) SHALL NOT start an update.

Reset
REQ-026 user_rst_n=0 SHALL asynchronously force IDLE, with reg_q, candidate, active, counter, b10, b11, coeff_valid, update_pulse, pending and update_count all set to 0.
REQ-027 Reset in mid-SETTLE or mid-ARMED SHALL discard the candidate; after release, a nonzero reg_data SHALL restart the full settle sequence.

Structure
REQ-028 The shared package fir_coeff_pkg SHALL hold the state enum and the defaults for COEF_W and SETTLE_CYCLES.
REQ-029 The block SHALL be a single module with no sub-module; the counter and compare logic are inline.

Verification
REQ-030 Reset release, reg_data=0x00000000, 20 cycles of sync_in -> no update_pulse, coeff_valid=0, b10=b11=0.
REQ-031 reg_data=0x1234ABCD stable, sync_in at the ARMED cycle -> b10=0x1234, b11=0xABCD one cycle later, update_pulse for 1 cycle, update_count=1.
REQ-032 reg_data toggles 0x1/0x2 every 2 cycles with SETTLE_CYCLES=4 -> the FSM never reaches ARMED and sync_in is ignored; once the value holds at 0x2, the update applies after the full settle.
REQ-033 In ARMED, reg_data changes on the same cycle as sync_in -> no update, FSM to SETTLE; the next sync after re-arming applies the new word.
REQ-034 Apply 256 distinct updates -> update_count wraps to 0 and coeff_valid stays 1.
REQ-035 Assert user_rst_n low mid-ARMED -> all outputs 0 immediately; after release the held word applies only after SETTLE_CYCLES plus a sync.

Source files
------------

// File: rtl/fir_coeff_pkg.sv
// -----------------------------------------------------------------------------
// fir_coeff_pkg
// Shared definitions for the FIR coefficient loader: default widths and settle
// length, plus the loader's state encoding.
// -----------------------------------------------------------------------------
package fir_coeff_pkg;

   // Each coefficient is COEF_W bits; two of them fill one 32-bit register word
   localparam int COEF_W_DEFAULT        = 16;

   // Number of consecutive identical samples before a new word may be applied
   localparam int SETTLE_CYCLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ARMED  = 2'd2
   } state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Takes a coefficient word from a software register and swaps it into the
// active FIR coefficient pair only after the word has been stable for a
// number of cycles and a frame sync arrives, so the filter never sees a
// half-written or glitching coefficient set.
//
// Ports
//   user_clk     : single rising-edge clock
//   user_rst_n   : asynchronous active-low reset
//   reg_data     : register word, [31:16] -> b10, [15:0] -> b11
//   sync_in      : frame sync; coefficients only change on this event
//   en           : enables starting a new update from idle
//   b10, b11     : active signed coefficients
//   coeff_valid  : high once any update has been applied
//   update_pulse : one-cycle strobe per applied update
//   pending      : high while a candidate word is settling or armed
//   update_count : applied updates, wrapping modulo 256
// -----------------------------------------------------------------------------
module fir_coeff_loader
   import fir_coeff_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter int COEF_W        = COEF_W_DEFAULT
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   input  logic [2*COEF_W-1:0]   reg_data,
   input  logic                  sync_in,
   input  logic                  en,
   output logic [COEF_W-1:0]     b10,
   output logic [COEF_W-1:0]     b11,
   output logic                  coeff_valid,
   output logic                  update_pulse,
   output logic                  pending,
   output logic [7:0]            update_count
);

   localparam int         WORD_W      = 2 * COEF_W;
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t              state;
   state_t              state_next;
   logic [WORD_W-1:0]   reg_q;
   logic [WORD_W-1:0]   candidate;
   logic [WORD_W-1:0]   active;
   logic [7:0]          counter;
   logic [7:0]          counter_inc;
   logic                load_cand;
   logic                inc_cnt;
   logic                apply;

   assign counter_inc = counter + 8'd1;

   // Coefficients come straight from the active word; active is a register,
   // so the outputs are glitch-free
   assign b10     = active[WORD_W-1:COEF_W];
   assign b11     = active[COEF_W-1:0];
   assign pending = (state == ST_SETTLE) || (state == ST_ARMED);

   // State register
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode. A change of the sampled word always restarts the
   // settle window, and that restart wins over a sync arriving in the same
   // cycle, so a word that moved at the last moment is never applied.
   // The ARMED transition fires on the edge where the counter reaches
   // SETTLE_CYCLES-1.
   always_comb begin
      state_next = state;
      load_cand  = 1'b0;
      inc_cnt    = 1'b0;
      apply      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && (reg_q != active)) begin
               load_cand  = 1'b1;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (reg_q != candidate) begin
               load_cand = 1'b1;
            end else begin
               inc_cnt = 1'b1;
               if (counter_inc >= SETTLE_LAST) begin
                  state_next = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (reg_q != candidate) begin
               load_cand  = 1'b1;
               state_next = ST_SETTLE;
            end else if (sync_in) begin
               apply      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: input sampling register, candidate capture, settle counter
   // and the active word with its bookkeeping outputs
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         reg_q        <= '0;
         candidate    <= '0;
         active       <= '0;
         counter      <= '0;
         coeff_valid  <= 1'b0;
         update_pulse <= 1'b0;
         update_count <= '0;
      end else begin
         reg_q        <= reg_data;
         update_pulse <= apply;
         if (load_cand) begin
            candidate <= reg_q;
            counter   <= '0;
         end else if (inc_cnt) begin
            counter <= counter_inc;
         end
         if (apply) begin
            active       <= candidate;
            coeff_valid  <= 1'b1;
            update_count <= update_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
// Self-checking bench for fir_coeff_loader. A behavioural model tracks the
// pending candidate as "value plus how long it has been stable" and is
// compared with the DUT outputs on every falling edge; directed sequences
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

   localparam int S = 4;

   logic        user_clk;
   logic        user_rst_n;
   logic [31:0] reg_data;
   logic        sync_in;
   logic        en;
   logic [15:0] b10;
   logic [15:0] b11;
   logic        coeff_valid;
   logic        update_pulse;
   logic        pending;
   logic [7:0]  update_count;

   int tests_run;
   int tests_failed;
   bit cmp_en;

   // Behavioural model state
   logic [31:0] m_regq;
   logic [31:0] m_active;
   logic [31:0] m_cand;
   int          m_age;
   bit          m_pending;
   bit          m_pulse;
   bit          m_valid;
   int          m_count;

   fir_coeff_loader #(
      .SETTLE_CYCLES (S),
      .COEF_W        (16)
   ) dut (
      .user_clk     (user_clk),
      .user_rst_n   (user_rst_n),
      .reg_data     (reg_data),
      .sync_in      (sync_in),
      .en           (en),
      .b10          (b10),
      .b11          (b11),
      .coeff_valid  (coeff_valid),
      .update_pulse (update_pulse),
      .pending      (pending),
      .update_count (update_count)
   );

   // Clock generation
   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive inputs just after a rising edge, then advance n cycles
   task automatic apply_stimulus(input logic [31:0] data, input logic sync, input logic enable,
                                 input int n);
      reg_data = data;
      sync_in  = sync;
      en       = enable;
      repeat (n) begin
         @(posedge user_clk);
         #1;
      end
   endtask

   // Reference model: the word seen by the loader is last cycle's reg_data.
   // A candidate is "armed" once it has been seen unchanged for S-1 further
   // cycles; a sync while armed and still unchanged commits it.
   always @(posedge user_clk or negedge user_rst_n) begin
      logic [31:0] seen;
      if (!user_rst_n) begin
         m_regq    = '0;
         m_active  = '0;
         m_cand    = '0;
         m_age     = 0;
         m_pending = 0;
         m_pulse   = 0;
         m_valid   = 0;
         m_count   = 0;
      end else begin
         seen    = m_regq;
         m_regq  = reg_data;
         m_pulse = 0;
         if (!m_pending) begin
            if (en && (seen != m_active)) begin
               m_pending = 1;
               m_cand    = seen;
               m_age     = 0;
            end
         end else if (seen != m_cand) begin
            m_cand = seen;
            m_age  = 0;
         end else if (m_age >= S - 1) begin
            if (sync_in) begin
               m_active  = m_cand;
               m_pending = 0;
               m_pulse   = 1;
               m_valid   = 1;
               m_count   = (m_count + 1) % 256;
            end
         end else begin
            m_age++;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge user_clk) begin
      if (cmp_en && user_rst_n) begin
         check_output("model_b10",          32'(b10),          32'(m_active[31:16]));
         check_output("model_b11",          32'(b11),          32'(m_active[15:0]));
         check_output("model_coeff_valid",  32'(coeff_valid),  32'(m_valid));
         check_output("model_update_pulse", 32'(update_pulse), 32'(m_pulse));
         check_output("model_pending",      32'(pending),      32'(m_pending));
         check_output("model_update_count", 32'(update_count), 32'(m_count));
      end
   end

   initial begin
      logic [31:0] pool [4];
      tests_run    = 0;
      tests_failed = 0;
      cmp_en       = 0;
      user_rst_n   = 1'b0;
      reg_data     = '0;
      sync_in      = 1'b0;
      en           = 1'b0;
      pool[0] = 32'h1111_2222;
      pool[1] = 32'h8000_7FFF;
      pool[2] = 32'hFFFF_0001;
      pool[3] = 32'h0000_0000;

      // Reset state
      repeat (3) @(posedge user_clk);
      #2;
      check_output("rst_b10",          32'(b10),          32'h0);
      check_output("rst_b11",          32'(b11),          32'h0);
      check_output("rst_coeff_valid",  32'(coeff_valid),  32'h0);
      check_output("rst_update_pulse", 32'(update_pulse), 32'h0);
      check_output("rst_pending",      32'(pending),      32'h0);
      check_output("rst_update_count", 32'(update_count), 32'h0);
      @(negedge user_clk);
      user_rst_n = 1'b1;
      cmp_en     = 1;
      @(posedge user_clk);
      #1;

      // A zero word equals the reset value of active: no update ever starts
      apply_stimulus(32'h0, 1'b1, 1'b1, 20);
      @(negedge user_clk);
      check_output("zero_coeff_valid", 32'(coeff_valid), 32'h0);
      check_output("zero_b10",         32'(b10),         32'h0);
      check_output("zero_count",       32'(update_count), 32'h0);

      // Stable word with sync held: applied at t+1+S+1 after the change
      @(posedge user_clk);
      #1;
      reg_data = 32'h1234_ABCD;
      @(posedge user_clk);
      @(negedge user_clk);
      check_output("lat_pending_t1", 32'(pending), 32'h0);
      @(posedge user_clk);
      @(negedge user_clk);
      check_output("lat_pending_t2", 32'(pending), 32'h1);
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      check_output("lat_pulse_t5", 32'(update_pulse), 32'h0);
      check_output("lat_b10_t5",   32'(b10),          32'h0);
      @(posedge user_clk);
      @(negedge user_clk);
      check_output("lat_b10_t6",   32'(b10),          32'h1234);
      check_output("lat_b11_t6",   32'(b11),          32'hABCD);
      check_output("lat_pulse_t6", 32'(update_pulse), 32'h1);
      check_output("lat_count_t6", 32'(update_count), 32'h1);
      check_output("lat_valid_t6", 32'(coeff_valid),  32'h1);
      sync_in = 1'b0;
      @(posedge user_clk);
      @(negedge user_clk);
      check_output("lat_pulse_t7",   32'(update_pulse), 32'h0);
      check_output("lat_pending_t7", 32'(pending),      32'h0);
      @(posedge user_clk);
      #1;

      // Word toggling every 2 cycles never settles, so sync is ignored
      for (int k = 0; k < 6; k++) begin
         apply_stimulus(32'h1, 1'b1, 1'b1, 2);
         apply_stimulus(32'h2, 1'b1, 1'b1, 2);
      end
      @(negedge user_clk);
      check_output("toggle_count", 32'(update_count), 32'h1);
      check_output("toggle_b11",   32'(b11),          32'hABCD);
      @(posedge user_clk);
      #1;
      apply_stimulus(32'h2, 1'b1, 1'b1, 8);
      @(negedge user_clk);
      check_output("hold_b10",   32'(b10),          32'h0);
      check_output("hold_b11",   32'(b11),          32'h2);
      check_output("hold_count", 32'(update_count), 32'h2);
      @(posedge user_clk);
      #1;

      // Word changing in the same cycle as the armed sync: restart, no update
      apply_stimulus(32'h5555_6666, 1'b0, 1'b1, 6);
      check_output("race_armed_pending", 32'(pending), 32'h1);
      apply_stimulus(32'h7777_8888, 1'b0, 1'b1, 1);
      apply_stimulus(32'h7777_8888, 1'b1, 1'b1, 1);
      apply_stimulus(32'h7777_8888, 1'b0, 1'b1, 1);
      @(negedge user_clk);
      check_output("race_count",   32'(update_count), 32'h2);
      check_output("race_pulse",   32'(update_pulse), 32'h0);
      check_output("race_b10",     32'(b10),          32'h0);
      check_output("race_pending", 32'(pending),      32'h1);
      @(posedge user_clk);
      #1;
      apply_stimulus(32'h7777_8888, 1'b0, 1'b1, 5);
      apply_stimulus(32'h7777_8888, 1'b1, 1'b1, 1);
      @(negedge user_clk);
      check_output("rearm_b10",   32'(b10),          32'h7777);
      check_output("rearm_b11",   32'(b11),          32'h8888);
      check_output("rearm_count", 32'(update_count), 32'h3);
      check_output("rearm_pulse", 32'(update_pulse), 32'h1);
      @(posedge user_clk);
      #1;

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(3) == 0) reg_data = pool[$urandom_range(3)];
         sync_in = ($urandom_range(3) == 0);
         en      = ($urandom_range(3) != 0);
         @(posedge user_clk);
         #1;
      end

      // Fresh reset, then 256 distinct updates: the counter wraps to 0
      @(negedge user_clk);
      user_rst_n = 1'b0;
      @(posedge user_clk);
      @(negedge user_clk);
      user_rst_n = 1'b1;
      @(posedge user_clk);
      #1;
      for (int i = 1; i <= 256; i++) begin
         apply_stimulus({16'(i), ~16'(i)}, 1'b1, 1'b1, 7);
         if (i == 255) check_output("wrap_count_255", 32'(update_count), 32'd255);
      end
      @(negedge user_clk);
      check_output("wrap_count_0", 32'(update_count), 32'h0);
      check_output("wrap_valid",   32'(coeff_valid),  32'h1);
      @(posedge user_clk);
      #1;

      // Reset while armed clears everything at once; the held word must then
      // settle again from scratch
      apply_stimulus(32'hCAFE_F00D, 1'b0, 1'b1, 5);
      check_output("armed_before_rst", 32'(pending), 32'h1);
      sync_in = 1'b1;
      #1;
      user_rst_n = 1'b0;
      #1;
      check_output("midrst_b10",     32'(b10),          32'h0);
      check_output("midrst_b11",     32'(b11),          32'h0);
      check_output("midrst_valid",   32'(coeff_valid),  32'h0);
      check_output("midrst_pulse",   32'(update_pulse), 32'h0);
      check_output("midrst_pending", 32'(pending),      32'h0);
      check_output("midrst_count",   32'(update_count), 32'h0);
      @(negedge user_clk);
      user_rst_n = 1'b1;
      repeat (5) @(posedge user_clk);
      @(negedge user_clk);
      check_output("postrst_count_r5",   32'(update_count), 32'h0);
      check_output("postrst_pending_r5", 32'(pending),      32'h1);
      @(posedge user_clk);
      @(negedge user_clk);
      check_output("postrst_count_r6", 32'(update_count), 32'h1);
      check_output("postrst_pulse_r6", 32'(update_pulse), 32'h1);
      check_output("postrst_b10_r6",   32'(b10),          32'hCAFE);
      check_output("postrst_b11_r6",   32'(b11),          32'hF00D);
      sync_in = 1'b0;
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);

      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
